// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, fetch FSM states and the reset PC.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_RESET = 32'h0000_0000;

  // Sequential successor of a word-aligned PC; wraps modulo 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

  // Force a redirect target onto a word boundary.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: instruction word, PC+4 and valid bit.
// Flush has priority over load and produces a bubble (valid=0, SLL NOP = 0);
// the npc field is left alone by a flush since decode ignores it for bubbles.
module ifid_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_npc,
  input  logic        i_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_npc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;

  // Stage register: flush -> bubble, load -> capture, otherwise hold.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr <= 32'd0;
      r_npc   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_npc   <= i_npc;
      r_valid <= i_valid;
    end else begin
      r_instr <= r_instr;
      r_npc   <= r_npc;
      r_valid <= r_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_npc   = r_npc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/FETCH/HALTED FSM, icache read
// request and the IF/ID stage register (ifid_latch).
// Optional feature macro: FETCH_PERF_EN builds the fetch_count / miss_cycles
// counters; when undefined both ports read as zero and no counter flops exist.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_RESET
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ifid_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pc_inc;
  logic         w_hit;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  logic         w_ifid_valid;

  assign w_pc_inc = pc_plus4(r_pc);

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: one BOOT cycle, then fetch until a qualified halt.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        if (halt_in && w_ifid_valid && !redirect_en) begin
          w_state_next = HALTED;
        end else begin
          w_state_next = FETCH;
        end
      end
      HALTED: begin
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  // FSM outputs: read the icache only while fetching.
  always_comb begin
    iREN   = 1'b0;
    halted = 1'b0;
    case (r_state)
      BOOT: begin
        iREN   = 1'b0;
        halted = 1'b0;
      end
      FETCH: begin
        iREN   = 1'b1;
        halted = 1'b0;
      end
      HALTED: begin
        iREN   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        iREN   = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  // Per-cycle datapath control: redirect > stall > hit > miss while fetching.
  always_comb begin
    w_pc_next    = r_pc;
    w_hit        = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    case (r_state)
      BOOT: begin
        if (redirect_en) begin
          w_pc_next    = word_align(redirect_pc);
          w_ifid_flush = 1'b1;
        end else begin
          w_pc_next    = r_pc;
        end
      end
      FETCH: begin
        if (redirect_en) begin
          // A concurrent ihit belongs to the wrong path and is dropped.
          w_pc_next    = word_align(redirect_pc);
          w_ifid_flush = 1'b1;
        end else if (ifid_stall) begin
          // The icache re-supplies the word once the stall lifts.
          w_pc_next    = r_pc;
        end else if (ihit) begin
          w_hit        = 1'b1;
          w_ifid_load  = 1'b1;
          w_pc_next    = w_pc_inc;
        end else begin
          w_ifid_flush = 1'b1;
        end
      end
      HALTED: begin
        if (ifid_stall) begin
          w_ifid_flush = 1'b0;
        end else begin
          w_ifid_flush = 1'b1;
        end
      end
      default: begin
        w_pc_next = r_pc;
      end
    endcase
  end

  // PC register; iaddr is the PC itself.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc <= PC_INIT;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign iaddr = r_pc;

  ifid_latch u_ifid (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_instr (iload),
    .i_npc   (w_pc_inc),
    .i_valid (1'b1),
    .o_instr (ifid_instr),
    .o_npc   (ifid_npc),
    .o_valid (w_ifid_valid)
  );

  assign ifid_valid = w_ifid_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_miss_cycles;
  logic        w_miss;

  assign w_miss = (r_state == FETCH) && !ihit && !ifid_stall && !redirect_en;

  // Perf counters; they only move in FETCH, so they freeze once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_count <= 32'd0;
      r_miss_cycles <= 32'd0;
    end else begin
      r_fetch_count <= w_hit  ? r_fetch_count + 32'd1 : r_fetch_count;
      r_miss_cycles <= w_miss ? r_miss_cycles + 32'd1 : r_miss_cycles;
    end
  end

  assign fetch_count = r_fetch_count;
  assign miss_cycles = r_miss_cycles;
`else
  assign fetch_count = 32'd0;
  assign miss_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ifid_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] miss_cycles;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_npc, m_fc, m_mc;
  bit          m_valid, m_started, m_halt;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN),
    .iaddr(iaddr), .ifid_stall(ifid_stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt_in(halt_in), .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .halted(halted),
    .fetch_count(fetch_count), .miss_cycles(miss_cycles)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_fc = 32'h0; m_mc = 32'h0;
    m_valid = 1'b0; m_started = 1'b0; m_halt = 1'b0;
  endtask

  // One rising edge of the fetch stage, from the rules in priority order.
  task automatic model_edge();
    bit go_halt;
    if (m_halt) begin
      if (!ifid_stall) begin m_valid = 1'b0; m_instr = 32'h0; end
    end else if (!m_started) begin
      if (redirect_en) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = 32'h0;
      end
      m_started = 1'b1;
    end else begin
      go_halt = halt_in && m_valid && !redirect_en;
      if (redirect_en) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = 32'h0;
      end else if (ifid_stall) begin
        // everything holds
      end else if (ihit) begin
        m_instr = iload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_fc = m_fc + 32'd1;
      end else begin
        m_valid = 1'b0; m_instr = 32'h0; m_mc = m_mc + 32'd1;
      end
      m_halt = go_halt;
    end
  endtask

  task automatic check_all();
    check("iaddr",       iaddr,               m_pc);
    check("iREN",        {31'd0, iREN},       {31'd0, m_started && !m_halt});
    check("ifid_instr",  ifid_instr,          m_instr);
    check("ifid_npc",    ifid_npc,            m_npc);
    check("ifid_valid",  {31'd0, ifid_valid}, {31'd0, m_valid});
    check("halted",      {31'd0, halted},     {31'd0, m_halt});
    check("fetch_count", fetch_count,         perf(m_fc));
    check("miss_cycles", miss_cycles,         perf(m_mc));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit hit, input bit stall, input bit redir,
                        input logic [31:0] rpc, input bit halt);
    ihit = hit; ifid_stall = stall; redirect_en = redir; redirect_pc = rpc;
    halt_in = halt; iload = $urandom;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    nRST = 1'b1;
  endtask

  task automatic random_run(input int cycles, input bit allow_halt);
    for (int i = 0; i < cycles; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0, $urandom,
             allow_halt && ($urandom_range(0, 49) == 0));
      step();
    end
  endtask

  initial begin
    logic [31:0] fc0, mc0;
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_reset();
    check("reset_iaddr", iaddr, 32'h0);

    // Reset release with ihit tied high: one BOOT cycle, then 0,4,8.
    step();
    check("boot_iREN", {31'd0, iREN}, 32'd1);
    check("boot_iaddr", iaddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("seq_iaddr", iaddr, 32'd4 * (i + 1));
      check("seq_npc", ifid_npc, 32'd4 * (i + 1));
    end

    random_run(150, 1'b0);

    // Redirect to 0x10 then three misses.
    set_in(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    step();
    mc0 = m_mc;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      check("miss_pc", iaddr, 32'h10);
      check("miss_valid", {31'd0, ifid_valid}, 32'd0);
    end
    check("miss_cnt", miss_cycles, perf(mc0 + 32'd3));

    // Stall with ihit for two cycles, then release: one fetch.
    fc0 = m_fc;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      iload = 32'hDEAD_BEEF;
      step();
      check("stall_pc", iaddr, 32'h10);
      check("stall_valid", {31'd0, ifid_valid}, 32'd0);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    iload = 32'hDEAD_BEEF;
    step();
    check("unstall_instr", ifid_instr, 32'hDEAD_BEEF);
    check("unstall_npc", ifid_npc, 32'h14);
    check("unstall_cnt", fetch_count, perf(fc0 + 32'd1));

    // Redirect with simultaneous ihit and stall.
    fc0 = m_fc;
    set_in(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    step();
    check("redir_pc", iaddr, 32'h200);
    check("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check("redir_cnt", fetch_count, perf(fc0));

    // PC wrap at the top of the address space.
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step();
    check("wrap_pre", iaddr, 32'hFFFF_FFFC);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("wrap_pc", iaddr, 32'h0);
    check("wrap_npc", ifid_npc, 32'h0);

    // Halt combined with redirect redirects instead.
    set_in(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    step();
    check("halt_redir_pc", iaddr, 32'h40);
    check("halt_redir_h", {31'd0, halted}, 32'd0);

    // Real halt, then redirects and hits are ignored.
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_iREN", {31'd0, iREN}, 32'd0);
    set_in(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    step();
    check("halt_ignore_pc", iaddr, 32'h44);
    random_run(20, 1'b0);

    // Reset mid-run, then random traffic including halts.
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    apply_reset();
    random_run(300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
